v_issue_seq: RTL

//  Vector instruction sequencer between the vector decoder and the functional units (FUs):

---
 rtl/v_pkg.sv | 35 +++
 rtl/v_scoreboard.sv | 37 +++
 rtl/v_issue_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/v_pkg.sv
// Shared vector-unit definitions: FU selector, sequencer FSM states, scoreboard depth,
// the held-instruction record and the reserved vsew encoding.
package v_pkg;

    localparam int NUM_VREG = 32;

    localparam logic [1:0] VSEW_INVALID = 2'b11;

    typedef enum logic [2:0] {
        VFU_ALU  = 3'd0,
        VFU_MUL  = 3'd1,
        VFU_RED  = 3'd2,
        VFU_SLDU = 3'd3,
        VFU_LSU  = 3'd4
    } vfu_sel_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ISSUE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [2:0] fu;
        logic [3:0] op;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic       rd_vs1;
        logic       rd_vs2;
        logic       wr_vd;
        logic [1:0] vsew;
    } seq_instr_t;

endpackage

// File: rtl/v_scoreboard.sv
// Per-vreg pending-write bits with a single set port, a multi-bit clear mask and a
// combinational RAW/WAW hazard query. A set and a clear on the same register resolve to set.
module v_scoreboard #(
    parameter int NUM_VREG = 32
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                set_en,
    input  logic [4:0]          set_idx,
    input  logic [NUM_VREG-1:0] clr_mask,
    input  logic [4:0]          q_vd,
    input  logic [4:0]          q_vs1,
    input  logic [4:0]          q_vs2,
    input  logic                q_rd_vs1,
    input  logic                q_rd_vs2,
    input  logic                q_wr_vd,
    output logic                hazard
);

    logic [NUM_VREG-1:0] pend;
    logic [NUM_VREG-1:0] set_mask;

    assign set_mask = set_en ? (NUM_VREG'(1) << set_idx) : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr_mask) | set_mask;
        end
    end

    assign hazard = (q_rd_vs1 & pend[q_vs1]) |
                    (q_rd_vs2 & pend[q_vs2]) |
                    (q_wr_vd  & pend[q_vd]);

endmodule

// File: rtl/v_issue_seq.sv
// Vector issue sequencer: holds one decoded instruction until its FU is free and no vreg
// hazard remains, then issues it. Define V_ISSUE_SEQ_PERF_EN to add the perf counters.
module v_issue_seq #(
    parameter int NUM_VREG = v_pkg::NUM_VREG,
    parameter int NUM_FU   = int'(v_pkg::VFU_LSU) + 1,
    parameter int VL_W     = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fu,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_vd,
    input  logic [4:0]        in_vs1,
    input  logic [4:0]        in_vs2,
    input  logic              in_rd_vs1,
    input  logic              in_rd_vs2,
    input  logic              in_wr_vd,
    input  logic [VL_W-1:0]   in_vl,
    input  logic [1:0]        in_vsew,
    output logic [NUM_FU-1:0] fu_issue,
    output logic [3:0]        fu_op,
    output logic [4:0]        fu_vd,
    output logic [4:0]        fu_vs1,
    output logic [4:0]        fu_vs2,
    output logic [VL_W-1:0]   fu_vl,
    output logic [1:0]        fu_vsew,
    input  logic [NUM_FU-1:0] fu_done,
    output logic              illegal,
    output logic              idle
`ifdef V_ISSUE_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_illegal
`endif
);

    import v_pkg::*;

    seq_state_e          state;
    seq_instr_t          held;
    logic [VL_W-1:0]     held_vl;
    logic [NUM_FU-1:0]   busy;
    logic [NUM_FU-1:0]   fu_wr_q;
    logic [4:0]          fu_vd_q [NUM_FU];
    logic [NUM_FU-1:0]   done_eff;
    logic [NUM_FU-1:0]   issue_mask;
    logic [NUM_VREG-1:0] clr_mask;
    logic                bad_instr;
    logic                reg_hazard;
    logic                hazard;
    logic                do_issue;
    logic                do_illegal;
    logic                do_stall;

    // Out-of-range FU indices are rejected before busy is ever looked up for them
    assign bad_instr  = (held.vsew == VSEW_INVALID) || (int'(held.fu) >= NUM_FU);
    assign hazard     = (!bad_instr && busy[held.fu]) || reg_hazard;
    assign do_illegal = (state == S_CHECK) && bad_instr;
    assign do_stall   = (state == S_CHECK) && !bad_instr && (held_vl != '0) && hazard;
    assign do_issue   = (state == S_ISSUE);
    assign issue_mask = do_issue ? (NUM_FU'(1) << held.fu) : '0;
    assign done_eff   = fu_done & busy;

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (done_eff[i] && fu_wr_q[i]) begin
                clr_mask[fu_vd_q[i]] = 1'b1;
            end
        end
    end

    v_scoreboard #(
        .NUM_VREG (NUM_VREG)
    ) u_scoreboard (
        .clk      (clk),
        .nrst     (nrst),
        .set_en   (do_issue && held.wr_vd),
        .set_idx  (held.vd),
        .clr_mask (clr_mask),
        .q_vd     (held.vd),
        .q_vs1    (held.vs1),
        .q_vs2    (held.vs2),
        .q_rd_vs1 (held.rd_vs1),
        .q_rd_vs2 (held.rd_vs2),
        .q_wr_vd  (held.wr_vd),
        .hazard   (reg_hazard)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            held    <= '0;
            held_vl <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        held <= '{fu: in_fu, op: in_op, vd: in_vd, vs1: in_vs1, vs2: in_vs2,
                                  rd_vs1: in_rd_vs1, rd_vs2: in_rd_vs2, wr_vd: in_wr_vd,
                                  vsew: in_vsew};
                        held_vl <= in_vl;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad_instr || (held_vl == '0)) begin
                        state <= S_IDLE;
                    end else if (!hazard) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Completions for idle FUs are dropped so stale pulses after a reset cannot clear anything
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy    <= '0;
            fu_wr_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                fu_vd_q[i] <= '0;
            end
        end else begin
            busy <= (busy & ~done_eff) | issue_mask;
            if (do_issue) begin
                fu_vd_q[held.fu] <= held.vd;
                fu_wr_q[held.fu] <= held.wr_vd;
            end
        end
    end

    assign in_ready = (state == S_IDLE);
    assign idle     = (state == S_IDLE) && (busy == '0);
    assign illegal  = do_illegal;
    assign fu_issue = issue_mask;
    assign fu_op    = do_issue ? held.op   : '0;
    assign fu_vd    = do_issue ? held.vd   : '0;
    assign fu_vs1   = do_issue ? held.vs1  : '0;
    assign fu_vs2   = do_issue ? held.vs2  : '0;
    assign fu_vl    = do_issue ? held_vl   : '0;
    assign fu_vsew  = do_issue ? held.vsew : '0;

`ifdef V_ISSUE_SEQ_PERF_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_issued  <= '0;
            perf_stall   <= '0;
            perf_illegal <= '0;
        end else begin
            perf_issued  <= perf_issued  + 32'(do_issue);
            perf_stall   <= perf_stall   + 32'(do_stall);
            perf_illegal <= perf_illegal + 32'(do_illegal);
        end
    end
`else
    logic unused_stall;
    assign unused_stall = do_stall;
`endif

endmodule
